alu_seq: RTL and testbench

//   Registered, parametrised successor to the 4-bit combinational lab ALU.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 67 ++++++
 rtl/alu_seq.sv | 142 ++++++++++++++
 tb/tb_alu_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_SUB = 3'b100,
    OP_MUL = 3'b101,
    OP_ACC = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] sum;

  always_comb begin
    sum      = prod_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if (busy_q) begin
      prod_d   = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Product is presented combinationally on the final iteration.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = sum;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with accumulator, optional multi-cycle MUL and
// valid/ready handshakes on both operand and result sides.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] res_hi,
  output logic             cout,
  output logic             err
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic               accept;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum_w, diff_w, acc_w;

  assign in_ready = (state_q == S_IDLE) && !mul_busy
                  && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  generate
    if (MUL_EN != 0) begin : g_mul
      logic mul_start;
      assign mul_start = accept && (op == OP_MUL);
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    diff_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c};
    acc_w  = {1'b0, acc_q} + {1'b0, a};
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    res_hi_d    = res_hi_q;
    cout_d      = cout_q;
    err_d       = err_q;
    acc_d       = acc_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (state_q == S_MUL) begin
      if (mul_done) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        {res_hi_d, result_d} = mul_prod;
        cout_d      = 1'b0;
        err_d       = 1'b0;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      res_hi_d    = '0;
      cout_d      = 1'b0;
      err_d       = 1'b0;
      unique case (op_e'(op))
        OP_ADD: {cout_d, result_d} = sum_w;
        OP_AND: result_d = a & b;
        OP_OR:  result_d = a | b;
        OP_XOR: result_d = a ^ b;
        OP_SUB: {cout_d, result_d} = diff_w;
        OP_MUL: begin
          result_d = '0;
          if (MUL_EN != 0) begin
            state_d     = S_MUL;
            out_valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_ACC: begin
          {cout_d, acc_d} = acc_w;
          result_d = acc_w[WIDTH-1:0];
        end
        OP_CLR: begin
          acc_d    = '0;
          result_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      res_hi_q    <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      res_hi_q    <= res_hi_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign res_hi    = res_hi_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=4, MUL_EN=1 and 0).
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       c = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, cout, err;
  logic [3:0] result, res_hi;
  logic       d2_in_ready, d2_out_valid, d2_cout, d2_err;
  logic [3:0] d2_result, d2_res_hi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c(c), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .res_hi(res_hi),
    .cout(cout), .err(err)
  );

  alu_seq #(.WIDTH(4), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
    .op(op), .a(a), .b(b), .c(c), .out_valid(d2_out_valid),
    .out_ready(out_ready), .result(d2_result), .res_hi(d2_res_hi),
    .cout(d2_cout), .err(d2_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [3:0] aa, input logic [3:0] bb,
                       input logic cc);
    in_valid = v; op = o; a = aa; b = bb; c = cc;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    total++;
    if ({out_valid, result, res_hi, cout, err, in_ready} !== 12'h001) begin
      bad++;
      $display("FAIL reset got v=%b r=%h h=%h c=%b e=%b rdy=%b exp 0/0/0/0/0/1",
               out_valid, result, res_hi, cout, err, in_ready);
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1, 3'b000, 4'hF, 4'h1, 1);
    cyc();
    total++;
    if ({out_valid, cout, result} !== 6'b1_1_0001) begin
      bad++;
      $display("FAIL add_carry got v=%b c=%b r=%h exp v=1 c=1 r=1",
               out_valid, cout, result);
    end
    drive(1, 3'b000, 4'h7, 4'h8, 0);
    cyc();
    total++;
    if ({out_valid, cout, result} !== 6'b1_0_1111) begin
      bad++;
      $display("FAIL add_nocarry got v=%b c=%b r=%h exp v=1 c=0 r=F",
               out_valid, cout, result);
    end
    drive(0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_sweep();
    int s, er, ec;
    out_ready = 1'b1;
    for (int o = 0; o < 5; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int z = 0; z < 2; z++) begin
            total++;
            if (in_ready !== 1'b1) begin
              bad++;
              $display("FAIL sweep_ready op=%0d a=%0d b=%0d got %b exp 1",
                       o, x, y, in_ready);
            end
            drive(1, o[2:0], x[3:0], y[3:0], z[0]);
            cyc();
            ec = 0;
            case (o)
              0: begin s = x + y + z; er = s % 16; ec = s / 16; end
              1: er = x & y;
              2: er = x | y;
              3: er = x ^ y;
              default: begin
                s = x - y - z;
                er = (s + 32) % 16;
                ec = (x < y + z) ? 1 : 0;
              end
            endcase
            total++;
            if (out_valid !== 1'b1 || result !== er[3:0] || cout !== ec[0]
                || res_hi !== 4'h0) begin
              bad++;
              $display("FAIL sweep op=%0d a=%h b=%h c=%0d got v=%b r=%h c=%b h=%h exp r=%h c=%0d",
                       o, x[3:0], y[3:0], z, out_valid, result, cout, res_hi,
                       er[3:0], ec);
            end
          end
    drive(0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_sub();
    drive(1, 3'b100, 4'h3, 4'h5, 0);
    cyc();
    total++;
    if ({cout, result} !== 5'b1_1110) begin
      bad++;
      $display("FAIL sub_borrow got c=%b r=%h exp c=1 r=E", cout, result);
    end
    drive(1, 3'b100, 4'h5, 4'h3, 1);
    cyc();
    total++;
    if ({cout, result} !== 5'b0_0001) begin
      bad++;
      $display("FAIL sub_noborrow got c=%b r=%h exp c=0 r=1", cout, result);
    end
    drive(0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    drive(1, 3'b101, 4'hF, 4'hF, 0);
    cyc();
    total++;
    if (d2_out_valid !== 1'b1 || d2_err !== 1'b1 || d2_result !== 4'h0
        || d2_res_hi !== 4'h0) begin
      bad++;
      $display("FAIL mul_disabled got v=%b e=%b r=%h h=%h exp v=1 e=1 r=0 h=0",
               d2_out_valid, d2_err, d2_result, d2_res_hi);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mul_busy cycle=%0d got rdy=%b v=%b exp 0/0",
                 i, in_ready, out_valid);
      end
      if (i < 3) cyc();
    end
    cyc();
    total++;
    if (out_valid !== 1'b1 || {res_hi, result} !== 8'hE1 || err !== 1'b0
        || cout !== 1'b0) begin
      bad++;
      $display("FAIL mul_ff got v=%b p=%h e=%b c=%b exp v=1 p=E1 e=0 c=0",
               out_valid, {res_hi, result}, err, cout);
    end
    drive(1, 3'b101, 4'h6, 4'hB, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    cyc(); cyc(); cyc(); cyc();
    total++;
    if (out_valid !== 1'b1 || {res_hi, result} !== 8'h42) begin
      bad++;
      $display("FAIL mul_6x11 got v=%b p=%h exp v=1 p=42",
               out_valid, {res_hi, result});
    end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1, 3'b001, 4'hC, 4'hA, 0);
    cyc();
    total++;
    if (out_valid !== 1'b1 || result !== 4'h8) begin
      bad++;
      $display("FAIL bp_and got v=%b r=%h exp v=1 r=8", out_valid, result);
    end
    drive(1, 3'b000, 4'h1, 4'h1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (out_valid !== 1'b1 || result !== 4'h8 || cout !== 1'b0
          || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got v=%b r=%h c=%b rdy=%b exp 1/8/0/0",
                 i, out_valid, result, cout, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready got %b exp 1", in_ready);
    end
    cyc();
    total++;
    if (out_valid !== 1'b1 || result !== 4'h2) begin
      bad++;
      $display("FAIL bp_consume_accept got v=%b r=%h exp v=1 r=2",
               out_valid, result);
    end
    drive(0, 0, 0, 0, 0);
    cyc();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_acc();
    out_ready = 1'b1;
    drive(1, 3'b111, 4'h0, 4'h0, 0);
    cyc();
    drive(1, 3'b110, 4'h9, 4'h0, 0);
    cyc();
    total++;
    if ({cout, result} !== 5'b0_1001) begin
      bad++;
      $display("FAIL acc_first got c=%b r=%h exp c=0 r=9", cout, result);
    end
    drive(1, 3'b110, 4'h9, 4'h0, 0);
    cyc();
    total++;
    if ({cout, result} !== 5'b1_0010) begin
      bad++;
      $display("FAIL acc_wrap got c=%b r=%h exp c=1 r=2", cout, result);
    end
    drive(1, 3'b011, 4'h5, 4'hF, 0);
    cyc();
    drive(1, 3'b110, 4'h0, 4'h0, 0);
    cyc();
    total++;
    if ({cout, result} !== 5'b0_0010) begin
      bad++;
      $display("FAIL acc_persist got c=%b r=%h exp c=0 r=2", cout, result);
    end
    drive(0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    drive(1, 3'b101, 4'h3, 4'h5, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 4'h0) begin
      bad++;
      $display("FAIL rst_mid_mul got v=%b rdy=%b r=%h exp 0/1/0",
               out_valid, in_ready, result);
    end
    drive(1, 3'b110, 4'h1, 4'h0, 0);
    cyc();
    total++;
    if (out_valid !== 1'b1 || result !== 4'h1 || cout !== 1'b0) begin
      bad++;
      $display("FAIL rst_acc_cleared got v=%b r=%h c=%b exp 1/1/0",
               out_valid, result, cout);
    end
    drive(0, 0, 0, 0, 0);
    cyc(); cyc(); cyc(); cyc();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_stale_mul got v=%b exp 0", out_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_sweep();
    test_sub();
    test_mul();
    test_backpressure();
    test_acc();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
